// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - doorlock FSM: timed unlock, failed-attempt count, optional lockout
// Optional timed lockout with alarm is built only when DOORLOCK_LOCKOUT_EN is defined.
module doorlock_ctrl #(
    parameter int UNLOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic       match,
    output logic       unlock,
    output logic       err,
    output logic       alarm,
    output logic [2:0] fail_cnt,
    output logic [2:0] state
);

    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [2:0]    MAX_FAIL_C   = 3'(MAX_FAIL);
`ifdef DOORLOCK_LOCKOUT_EN
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPEN    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_LOCKOUT = 3'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      fail_cnt_q, fail_cnt_d;
    logic            enter_q, enter_d;
    logic            unlock_q, unlock_d;
    logic            err_q, err_d;
    logic            alarm_q, alarm_d;
    logic            attempt;
    logic [2:0]      fail_inc;

    assign attempt = enter & ~enter_q;
    assign enter_d = enter;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        fail_inc   = (fail_cnt_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (attempt) begin
                    if (match) begin
                        state_d    = ST_OPEN;
                        timer_d    = UNLOCK_LOAD;
                        fail_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_OPEN: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            ST_FAIL: begin
                fail_cnt_d = fail_inc;
                state_d    = ST_IDLE;
`ifdef DOORLOCK_LOCKOUT_EN
                if (fail_inc == MAX_FAIL_C) begin
                    state_d = ST_LOCKOUT;
                    timer_d = LOCKOUT_LOAD;
                end
`endif
            end
`ifdef DOORLOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = 3'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are flopped from the next state so they change only on the clock edge.
        unlock_d = (state_d == ST_OPEN);
        err_d    = (state_d == ST_FAIL);
`ifdef DOORLOCK_LOCKOUT_EN
        alarm_d  = (state_d == ST_LOCKOUT);
`else
        alarm_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            fail_cnt_q <= 3'd0;
            enter_q    <= 1'b0;
            unlock_q   <= 1'b0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
            enter_q    <= enter_d;
            unlock_q   <= unlock_d;
            err_q      <= err_d;
            alarm_q    <= alarm_d;
        end
    end

    assign unlock   = unlock_q;
    assign err      = err_q;
    assign fail_cnt = fail_cnt_q;
    assign state    = state_q;
`ifdef DOORLOCK_LOCKOUT_EN
    assign alarm    = alarm_q;
`else
    assign alarm    = 1'b0;
`endif

endmodule
